// File: rtl/cpu_branch_pkg.sv
// cpu_branch_pkg: branch types, condition codes, FSM states and NZCV bit positions
package cpu_branch_pkg;
    typedef enum logic [1:0] {BR_B, BR_BCOND, BR_CBZ, BR_CBNZ} br_type_e;
    typedef enum logic [3:0] {EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE} bfu_state_e;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
endpackage

// File: rtl/cond_evaluator.sv
// cond_evaluator: LEGv8 condition code against an NZCV value
module cond_evaluator
    import cpu_branch_pkg::*;
(
    input  cond_e      cond,
    input  logic [3:0] nzcv,
    output logic       taken
);
    logic n, z, c, v;
    assign n = nzcv[N_BIT];
    assign z = nzcv[Z_BIT];
    assign c = nzcv[C_BIT];
    assign v = nzcv[V_BIT];
    always_comb begin
        taken = 1'b1;
        case (cond)
            EQ: taken = z;
            NE: taken = ~z;
            HS: taken = c;
            LO: taken = ~c;
            MI: taken = n;
            PL: taken = ~n;
            VS: taken = v;
            VC: taken = ~v;
            HI: taken = c & ~z;
            LS: taken = ~c | z;
            GE: taken = n == v;
            LT: taken = n != v;
            GT: taken = ~z & (n == v);
            LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/zero_checker.sv
// zero_checker: flags an all-zero input word
module zero_checker #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] data,
    output logic             is_zero
);
    assign is_zero = ~|data;
endmodule

// File: rtl/branch_flag_unit.sv
// branch_flag_unit: NZCV flag register, in-flight flag tracking and branch resolution
module branch_flag_unit
    import cpu_branch_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int MAX_PENDING = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flag_issue,
    input  logic             ex_set_flags,
    input  logic [WIDTH-1:0] ex_result,
    input  logic             ex_carry,
    input  logic             ex_overflow,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_operand,
    input  logic             squash,
    output logic             res_valid,
    output logic             res_taken,
    output logic [3:0]       nzcv,
    output logic             pend_err
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

    bfu_state_e    state_q, state_d;
    br_type_e      type_q, type_d;
    cond_e         cond_q, cond_d;
    logic          opz_q, opz_d;
    logic [3:0]    nzcv_q, nzcv_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          pend_err_q, pend_err_d;
    logic          res_z, op_z, cond_taken;

    zero_checker #(.WIDTH(WIDTH)) u_res_zero (.data(ex_result), .is_zero(res_z));
    zero_checker #(.WIDTH(WIDTH)) u_op_zero (.data(br_operand), .is_zero(op_z));
    cond_evaluator u_cond (.cond(cond_q), .nzcv(nzcv_q), .taken(cond_taken));

    always_comb begin
        nzcv_d     = ex_set_flags ? {ex_result[WIDTH-1], res_z, ex_carry, ex_overflow} : nzcv_q;
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        if (flag_issue && !ex_set_flags) begin
            pend_d     = (pend_q == PMAX) ? pend_q : pend_q + 1'b1;
            pend_err_d = pend_err_q | (pend_q == PMAX);
        end else if (ex_set_flags && !flag_issue) begin
            pend_d     = (pend_q == '0) ? pend_q : pend_q - 1'b1;
            pend_err_d = pend_err_q | (pend_q == '0);
        end
    end

    // B.cond only waits if flag writers remain after this edge
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        cond_d    = cond_q;
        opz_d     = opz_q;
        br_ready  = state_q == IDLE;
        res_valid = state_q == RESOLVE && !squash;
        case (state_q)
            IDLE: if (br_valid && !squash) begin
                type_d  = br_type_e'(br_type);
                cond_d  = cond_e'(br_cond);
                opz_d   = op_z;
                state_d = (type_d == BR_BCOND && pend_d != '0) ? WAIT_FLAGS : RESOLVE;
            end
            WAIT_FLAGS: state_d = squash ? IDLE : (pend_q == '0 ? RESOLVE : WAIT_FLAGS);
            default: state_d = IDLE;
        endcase
        res_taken = res_valid & (type_q == BR_B     ? 1'b1 :
                                 type_q == BR_BCOND ? cond_taken :
                                 type_q == BR_CBZ   ? opz_q : ~opz_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            type_q     <= BR_B;
            cond_q     <= EQ;
            opz_q      <= 1'b0;
            nzcv_q     <= '0;
            pend_q     <= '0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            cond_q     <= cond_d;
            opz_q      <= opz_d;
            nzcv_q     <= nzcv_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign nzcv     = nzcv_q;
    assign pend_err = pend_err_q;
endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Holds the architectural NZCV flag register and resolves branch decisions for the pipelined CPU.
- Zero-detection comes from two zero_checker instances:
  - one on the EX-stage ALU result, which produces the Z flag;
  - one on the branch operand, for CBZ/CBNZ.
- Takes branch requests from decode over a valid/ready handshake.
- Stalls B.cond until every in-flight flag-setting instruction has retired, then emits a one-cycle taken/not-taken result to the fetch/flush logic.

Parameters:
- WIDTH, 64, datapath width of ALU result and branch operand.
- MAX_PENDING, 3, max flag-setting instructions in flight between issue and EX writeback.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flag_issue  input  1  a flag-setting instruction left decode this cycle.
- ex_set_flags  input  1  EX-stage instruction sets flags this cycle (retires one pending).
- ex_result  input  WIDTH  ALU result.
- ex_carry  input  1  ALU carry-out.
- ex_overflow  input  1  ALU signed overflow.
- br_valid  input  1  branch request present.
- br_ready  output  1  unit can accept a request.
- br_type  input  2  0=B, 1=BCOND, 2=CBZ, 3=CBNZ.
- br_cond  input  4  LEGv8 condition code (BCOND only).
- br_operand  input  WIDTH  register value (CBZ/CBNZ only).
- squash  input  1  pipeline flush; abort the outstanding request.
- res_valid  output  1  one-cycle pulse, decision available.
- res_taken  output  1  decision, valid only with res_valid.
- nzcv  output  4  flag register {N,Z,C,V}.
- pend_err  output  1  sticky: counter overflow or underflow.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, nzcv=0000, pend_cnt=0, pend_err=0;
  - res_valid=0, res_taken=0, br_ready=1 after release.
- Flag register:
  - on a clk edge with ex_set_flags=1, nzcv <= {ex_result[WIDTH-1], zero(ex_result), ex_carry, ex_overflow};
  - otherwise it holds.
- pend_cnt, width clog2(MAX_PENDING+1):
  - +1 on flag_issue, -1 on ex_set_flags, unchanged when both occur.
  - issue alone at MAX_PENDING: saturates and sets pend_err.
  - retire alone at 0: stays 0 and sets pend_err.
  - pend_err clears only on reset.
- FSM states: IDLE, WAIT_FLAGS, RESOLVE.
  - IDLE: br_ready=1. On br_valid&br_ready, capture type, cond and opz=zero(br_operand).
    - BCOND with next-cycle pend_cnt≠0 -> WAIT_FLAGS.
    - Anything else -> RESOLVE.
  - WAIT_FLAGS: br_ready=0. Go to RESOLVE when registered pend_cnt==0. Resolution reads the registered nzcv, so a final ex_set_flags is visible.
  - RESOLVE: br_ready=0, res_valid=1 for exactly one cycle, then -> IDLE.
- Latency:
  - accept at edge N -> res_valid high during cycle N+1 (B, CBZ/CBNZ, BCOND with no pending).
  - BCOND: res_valid one cycle after the edge where pend_cnt reaches 0.
- Decision:
  - B: taken=1.
  - CBZ: taken=opz. CBNZ: taken=~opz.
  - BCOND evaluates nzcv:
    - EQ(0) Z; NE(1) ~Z;
    - HS(2) C; LO(3) ~C;
    - MI(4) N; PL(5) ~N;
    - VS(6) V; VC(7) ~V;
    - HI(8) C&~Z; LS(9) ~C|Z;
    - GE(A) N==V; LT(B) N!=V;
    - GT(C) ~Z&(N==V); LE(D) Z|(N!=V);
    - AL(E/F) 1.
- squash:
  - In WAIT_FLAGS or RESOLVE: -> IDLE next edge, res_valid forced 0 that cycle.
  - In IDLE: a concurrent request is not accepted.
  - Does not touch nzcv or pend_cnt.
- Reset mid-operation discards the request and drops res_valid immediately.
- br_ready depends only on state, never combinationally on br_valid.

Decomposition:
- Package cpu_branch_pkg:
  - br_type_e (B, BCOND, CBZ, CBNZ);
  - cond_e (EQ..AL, 4-bit);
  - bfu_state_e (IDLE, WAIT_FLAGS, RESOLVE);
  - NZCV bit-index constants.
- Sub-module cond_evaluator (combinational cond_e × nzcv -> taken).
- Two zero_checker instances, unmodified.

Test Plan:
- Reset, then ex_set_flags=1 with ex_result=0, carry=1, V=0 -> nzcv=0110 next cycle; accept BCOND EQ -> res_valid 1 cycle later, res_taken=1.
- CBZ with br_operand=64'h0000_0000_0001_0000 -> res_taken=0. CBNZ with the same operand -> res_taken=1. Both at latency 1, br_ready low for exactly one cycle.
- flag_issue twice, then BCOND LT -> FSM holds in WAIT_FLAGS. Retire ex_result=64'h8000_0000_0000_0000 with V=0, then a second retire -> res_valid the cycle after pend_cnt=0, res_taken=1.
- BCOND waiting in WAIT_FLAGS, assert squash -> no res_valid, br_ready=1 next cycle, nzcv unchanged.
- Four flag_issue with no retire -> pend_cnt saturates at 3, pend_err=1 and stays 1. Issue+retire in the same cycle -> count unchanged.
- reset_n pulsed low mid-WAIT_FLAGS -> res_valid=0, nzcv=0000, pend_cnt=0 immediately, without waiting for clk.
